// File: rtl/spi_pkg.sv
// Shared types and helpers for the SPI endpoints.
package spi_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        XFER = 1'b1
    } spi_slave_state_e;

    localparam int SYNC_STAGES = 2;

    // Selects the detected edge that corresponds to "leading" (or "trailing"
    // when rise/fall are swapped by the caller) for a given clock polarity.
    function automatic logic edge_pick(input logic pol, input logic rise, input logic fall);
        return pol ? fall : rise;
    endfunction

endpackage

// File: rtl/spi_slave_sync.sv
// Two-flop synchronizer for one asynchronous SPI pin, with rise/fall detect
// against the previous synchronized value.
module spi_slave_sync
    import spi_pkg::*;
(
    input  logic clk_i,
    input  logic rst_i,
    input  logic pin_i,
    output logic sync_o,
    output logic rise_o,
    output logic fall_o
);

    logic [SYNC_STAGES-1:0] stage;
    logic                   prev;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            stage <= '0;
            prev  <= 1'b0;
        end else begin
            stage <= {stage[SYNC_STAGES-2:0], pin_i};
            prev  <= stage[SYNC_STAGES-1];
        end
    end

    assign sync_o = stage[SYNC_STAGES-1];
    assign rise_o = stage[SYNC_STAGES-1] & ~prev;
    assign fall_o = ~stage[SYNC_STAGES-1] & prev;

endmodule

// File: rtl/spi_slave.sv
// SPI peripheral endpoint: oversamples sclk/ss_n/mosi in the clk_i domain,
// shifts a word in on mosi while shifting din_i out on miso.
module spi_slave
    import spi_pkg::*;
#(
    parameter int WordLength = 8
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  cpol_i,
    input  logic                  cpha_i,
    input  logic [WordLength-1:0] din_i,
    output logic [WordLength-1:0] dout_o,
    output logic                  rx_done_tick_o,
    output logic                  busy_o,
    input  logic                  sclk_i,
    input  logic                  ss_n_i,
    input  logic                  mosi_i,
    output logic                  miso_o,
    output spi_slave_state_e      dbg_state_o
);

    localparam int              CntW    = $clog2(WordLength);
    localparam logic [CntW-1:0] LastBit = CntW'(WordLength - 1);

    logic sclk_level, sclk_rise, sclk_fall;
    logic ss_level, ss_rise, ss_fall;
    logic mosi_level, mosi_rise, mosi_fall;
    logic unused_mosi_edges;

    spi_slave_sync u_sclk_sync (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .pin_i  (sclk_i),
        .sync_o (sclk_level),
        .rise_o (sclk_rise),
        .fall_o (sclk_fall)
    );

    spi_slave_sync u_ss_sync (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .pin_i  (ss_n_i),
        .sync_o (ss_level),
        .rise_o (ss_rise),
        .fall_o (ss_fall)
    );

    spi_slave_sync u_mosi_sync (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .pin_i  (mosi_i),
        .sync_o (mosi_level),
        .rise_o (mosi_rise),
        .fall_o (mosi_fall)
    );

    assign unused_mosi_edges = mosi_rise ^ mosi_fall ^ sclk_level;

    spi_slave_state_e      state;
    logic                  cpol_q, cpha_q;
    logic                  ss_armed;
    logic [WordLength-1:0] rx_reg, tx_reg;
    logic [CntW-1:0]       bit_cnt, tx_idx;

    logic lead_edge, trail_edge, sample_edge, drive_edge;
    logic [WordLength-1:0] rx_next;

    assign lead_edge   = edge_pick(cpol_q, sclk_rise, sclk_fall);
    assign trail_edge  = edge_pick(cpol_q, sclk_fall, sclk_rise);
    assign sample_edge = cpha_q ? trail_edge : lead_edge;
    assign drive_edge  = cpha_q ? lead_edge : trail_edge;
    assign rx_next     = {rx_reg[WordLength-2:0], mosi_level};

    // din_i is captured on the cycle the frame starts and on the cycle
    // rx_done_tick_o is raised; change it after either to queue the next word.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state          <= IDLE;
            cpol_q         <= 1'b0;
            cpha_q         <= 1'b0;
            ss_armed       <= 1'b0;
            rx_reg         <= '0;
            tx_reg         <= '0;
            bit_cnt        <= '0;
            tx_idx         <= '0;
            dout_o         <= '0;
            rx_done_tick_o <= 1'b0;
        end else begin
            rx_done_tick_o <= 1'b0;
            // ss_n must be seen high after reset before busy_o may report selection.
            if (ss_rise) begin
                ss_armed <= 1'b1;
            end
            case (state)
                IDLE: begin
                    if (ss_fall) begin
                        state   <= XFER;
                        cpol_q  <= cpol_i;
                        cpha_q  <= cpha_i;
                        tx_reg  <= din_i;
                        rx_reg  <= '0;
                        bit_cnt <= '0;
                        tx_idx  <= '0;
                    end
                end
                XFER: begin
                    if (ss_level) begin
                        state   <= IDLE;
                        rx_reg  <= '0;
                        bit_cnt <= '0;
                        tx_idx  <= '0;
                    end else begin
                        if (sample_edge) begin
                            rx_reg <= rx_next;
                            if (bit_cnt == LastBit) begin
                                bit_cnt        <= '0;
                                dout_o         <= rx_next;
                                rx_done_tick_o <= 1'b1;
                                tx_reg         <= din_i;
                            end else begin
                                bit_cnt <= bit_cnt + CntW'(1);
                            end
                        end
                        // Drive edges track the sample count: this gives the
                        // MSB on the first leading edge (cpha=1) and on the
                        // trailing edge after a word completes (cpha=0).
                        if (drive_edge) begin
                            tx_idx <= bit_cnt;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign miso_o      = (state == XFER) ? tx_reg[LastBit - tx_idx] : 1'b0;
    assign busy_o      = ss_armed & ~ss_level;
    assign dbg_state_o = state;

endmodule
